// File: rtl/mips_mdu.sv
// mips_mdu: multiply/divide unit for the pipelined MIPS core (EX stage).
// Executes mult, multu, div, divu, mthi and mtlo, and owns the HI/LO registers.
// The result is computed in a single cycle at issue and parked in pending
// registers. A down-counter then models the architectural latency, and HI/LO
// are committed on the same edge on which busy falls.
// Optional feature macro: MDU_MADD_EN turns md_op=7 into madd (HI:LO += a*b).
// When the macro is undefined, md_op=7 is a no-op.

module mips_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // md_op=0 is "none" and falls into the default decode arm.
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [0:0]  state_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;

    logic        is_mul_s;
    logic        is_div_s;
    logic        is_signed_s;
    logic        is_mthi_s;
    logic        is_mtlo_s;
`ifdef MDU_MADD_EN
    logic        is_madd_s;
`endif

    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] mul_res_s;

    logic        sign_a_s;
    logic        sign_b_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    logic [63:0] pend_next_s;

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Decode the operation code into operation classes.
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        is_mthi_s   = 1'b0;
        is_mtlo_s   = 1'b0;
`ifdef MDU_MADD_EN
        is_madd_s   = 1'b0;
`endif
        case (md_op)
            OP_MULT: begin
                is_mul_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            OP_MULTU: begin
                is_mul_s    = 1'b1;
            end
            OP_DIV: begin
                is_div_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            OP_DIVU: begin
                is_div_s    = 1'b1;
            end
            OP_MTHI: begin
                is_mthi_s   = 1'b1;
            end
            OP_MTLO: begin
                is_mtlo_s   = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                is_mul_s    = 1'b1;
                is_signed_s = 1'b1;
                is_madd_s   = 1'b1;
            end
`endif
            default: begin
                is_mul_s    = 1'b0;
            end
        endcase
    end

    // Multiplier: extend both operands to 64 bits (sign or zero) so that the
    // low 64 bits of a single product serve both signed and unsigned forms.
    assign mul_a_s   = {{32{is_signed_s & src_a[31]}}, src_a};
    assign mul_b_s   = {{32{is_signed_s & src_b[31]}}, src_b};
    assign mul_res_s = mul_a_s * mul_b_s;

    // Divider: an unsigned magnitude divide followed by sign fix-up. The
    // quotient truncates toward zero and the remainder takes the dividend's
    // sign. 0x80000000 / -1 falls out naturally as LO=0x80000000, HI=0.
    always_comb begin
        sign_a_s = is_signed_s & src_a[31];
        sign_b_s = is_signed_s & src_b[31];
        abs_a_s  = sign_a_s ? (32'd0 - src_a) : src_a;
        abs_b_s  = sign_b_s ? (32'd0 - src_b) : src_b;
        if (abs_b_s == 32'd0) begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = abs_a_s / abs_b_s;
            r_mag_s = abs_a_s % abs_b_s;
        end
        quot_s = (sign_a_s ^ sign_b_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s  = sign_a_s ? (32'd0 - r_mag_s) : r_mag_s;
    end

    // Select the HI:LO value to be committed once the latency has elapsed.
    // A divide by zero re-commits the current HI:LO, leaving it unchanged.
    always_comb begin
        pend_next_s = {hi_r, lo_r};
        if (is_div_s && (src_b != 32'd0)) begin
            pend_next_s = {rem_s, quot_s};
        end else if (is_div_s) begin
            pend_next_s = {hi_r, lo_r};
        end else begin
`ifdef MDU_MADD_EN
            pend_next_s = is_madd_s ? ({hi_r, lo_r} + mul_res_s) : mul_res_s;
`else
            pend_next_s = mul_res_s;
`endif
        end
    end

    // Control FSM, latency counter, pending result and the HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (is_mul_s || is_div_s)) begin
                        pend_hi_r <= pend_next_s[63:32];
                        pend_lo_r <= pend_next_s[31:0];
                        cnt_r     <= is_div_s ? DIV_CNT : MULT_CNT;
                        busy_r    <= 1'b1;
                        state_r   <= ST_RUN;
                    end else if (start && is_mthi_s) begin
                        hi_r <= src_a;
                    end else if (start && is_mtlo_s) begin
                        lo_r <= src_a;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // New issues are ignored here; the hazard unit stalls them.
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        hi_r    <= pend_hi_r;
                        lo_r    <= pend_lo_r;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    mips_mdu_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy_r)
    );

endmodule

// mips_mdu_chk: protocol checker for the multiply/divide unit.
// Reports an issue strobe that arrives while an operation is still in flight
// (the unit ignores it; the hazard unit should never let it happen).
module mips_mdu_chk (
    input logic clk,
    input logic rst_n,
    input logic start,
    input logic busy
);

    // Flags a start strobe seen while the unit is busy.
    a_no_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy))
        else $warning("mips_mdu: start strobe while busy was ignored");

endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: directed self-checking bench for mips_mdu.
// Drives inputs on the falling clock edge and samples outputs there as well.
// With MDU_MADD_EN defined, the madd accumulate path is exercised too.

module tb_mips_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          errors;

    // Bench model of the architectural HI/LO, set from hand-computed values.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mips_mdu #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle mthi/mtlo strobe with no checking; updates the model.
    task automatic move_to(input logic [2:0] op, input logic [31:0] val);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        src_a = val;
        src_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
        if (op == OP_MTHI) m_hi = val;
        else               m_lo = val;
    endtask

    // Issue a multi-cycle op, check busy length, HI/LO hold, then the commit.
    // inj > 0 drives a multu strobe at that cycle into the run (must be ignored).
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int inj);
        int busy_cnt;
        bit held;
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start    = 1'b0;
        md_op    = OP_NONE;
        busy_cnt = 0;
        held     = 1'b1;
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if ({hi, lo} !== {m_hi, m_lo}) held = 1'b0;
            if ((inj > 0) && (j == inj)) begin
                start = 1'b1;
                md_op = OP_MULTU;
                src_a = 32'd3;
                src_b = 32'd5;
            end else begin
                start = 1'b0;
                md_op = OP_NONE;
            end
        end
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(n));
        check({tag, " hold_old"}, 64'(held), 64'd1);
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
        check({tag, " busy_fall"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Directed test sequence.
    initial begin
        checks = 0;
        errors = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        rst_n  = 1'b0;
        start  = 1'b0;
        md_op  = OP_NONE;
        src_a  = 32'd0;
        src_b  = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // mthi then mtlo back to back
        @(negedge clk);
        start = 1'b1;
        md_op = OP_MTHI;
        src_a = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi hi", 64'(hi), 64'h00000000DEADBEEF);
        check("mthi busy", 64'(busy), 64'd0);
        md_op = OP_MTLO;
        src_a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
        check("mtlo lo", 64'(lo), 64'h0000000012345678);
        check("mtlo hi_kept", 64'(hi), 64'h00000000DEADBEEF);
        check("mtlo busy", 64'(busy), 64'd0);
        m_hi = 32'hDEADBEEF;
        m_lo = 32'h12345678;

        // Multiplies
        run_op("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, MULT_N, 32'h00000001, 32'hFFFFFFFE, 0);
        run_op("mult_negneg", OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, MULT_N, 32'h00000000, 32'h00000006, 0);

        // Divides
        run_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_N, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu", OP_DIVU, 32'd7, 32'd2, DIV_N, 32'h00000001, 32'h00000003, 0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h00000000, 32'h80000000, 0);

        // Divide by zero keeps preloaded HI/LO
        move_to(OP_MTHI, 32'h00000011);
        move_to(OP_MTLO, 32'h00000022);
        run_op("div0", OP_DIV, 32'd1234, 32'd0, DIV_N, 32'h00000011, 32'h00000022, 0);

        // No-op codes leave everything untouched
        @(negedge clk);
        start = 1'b1;
        md_op = OP_NONE;
        src_a = 32'hAAAA5555;
        src_b = 32'h5555AAAA;
`ifndef MDU_MADD_EN
        @(negedge clk);
        md_op = OP_RSVD;
`endif
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
        check("noop busy", 64'(busy), 64'd0);
        check("noop hilo", {hi, lo}, {m_hi, m_lo});

        // multu issued while a div is running is ignored (100/7 -> q=14 r=2)
        run_op("div_inject", OP_DIV, 32'd100, 32'd7, DIV_N, 32'h00000002, 32'h0000000E, 3);

        // Reset three cycles into a div: immediate clear, no later commit
        @(negedge clk);
        start = 1'b1;
        md_op = OP_DIVU;
        src_a = 32'd50;
        src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DIV_N + 2; k++) @(negedge clk);
        check("midrst no_commit", {hi, lo}, 64'd0);
        check("midrst busy_after", 64'(busy), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

`ifdef MDU_MADD_EN
        // madd: 0x0:0xFFFFFFFF + 1*1 -> 0x1:0x0
        move_to(OP_MTLO, 32'hFFFFFFFF);
        run_op("madd", OP_RSVD, 32'd1, 32'd1, MULT_N, 32'h00000001, 32'h00000000, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
